// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_ctrl_pkg : state encoding and counter-width helper for the       |
// |                 MIPS run/step/halt sequencer.  Rev 1.0                |
// +----------------------------------------------------------------------+
package mips_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_HALT = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_debounce : 2-flop synchronizer plus stable-sample debouncer.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mips_debounce
   import mips_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = 1250000
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int              c_CNT_W = cnt_width(DEB_CYCLES);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEB_CYCLES - 1);

   logic               r_s1;
   logic               r_s2;
   logic               r_db;
   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_db  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= din;
         r_s2 <= r_s1;
         // Only an unbroken run of differing samples may flip the output.
         if (r_s2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == c_LAST) begin
            r_db  <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign dout = r_db;

endmodule
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_run_ctrl : run/step/halt sequencer producing the CPU clock       |
// |                 enable, CPU reset and executed-cycle count. Rev 1.0   |
// +----------------------------------------------------------------------+
module mips_run_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int TICK_DIV   = 125000000,
   parameter int DEB_CYCLES = 1250000,
   parameter int RST_HOLD   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run_sw,
   input  logic        step_btn,
   input  logic        halt_req,
   output logic        cpu_reset,
   output logic        cpu_en,
   output logic [1:0]  state,
   output logic [31:0] cycle_count
);

   localparam int                  c_DIV_W   = cnt_width(TICK_DIV);
   localparam int                  c_HOLD_W  = cnt_width(RST_HOLD);
   localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(TICK_DIV - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD - 1);

   logic                w_run_db;
   logic                w_step_db;
   logic                w_step_pulse;
   logic                w_stop;

   state_t              r_state;
   logic                r_cpu_reset;
   logic                r_cpu_en;
   logic [31:0]         r_cycle_count;
   logic [c_HOLD_W-1:0] r_hold;
   logic [c_DIV_W-1:0]  r_div;
   logic                r_step_db_d;

   mips_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
      .clk   (clk),
      .reset (reset),
      .din   (run_sw),
      .dout  (w_run_db)
   );

   mips_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
      .clk   (clk),
      .reset (reset),
      .din   (step_btn),
      .dout  (w_step_db)
   );

   assign w_step_pulse = w_step_db & ~r_step_db_d;
   assign w_stop       = ~w_run_db | halt_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_RST;
         r_cpu_reset   <= 1'b1;
         r_cpu_en      <= 1'b0;
         r_cycle_count <= '0;
         r_hold        <= '0;
         r_div         <= '0;
         r_step_db_d   <= 1'b0;
      end else begin
         r_step_db_d <= w_step_db;
         if (r_cpu_en) begin
            r_cycle_count <= r_cycle_count + 32'd1;
         end
         case (r_state)
            ST_RST: begin
               r_cpu_en <= 1'b0;
               if (r_hold == c_HOLD_LAST) begin
                  r_state     <= ST_HALT;
                  r_cpu_reset <= 1'b0;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            ST_HALT: begin
               r_cpu_en <= 1'b0;
               if (!w_stop) begin
                  r_state <= ST_RUN;
                  r_div   <= '0;
               end else if (w_step_pulse) begin
                  r_state  <= ST_STEP;
                  r_cpu_en <= 1'b1;
               end
            end
            ST_RUN: begin
               // A stop request suppresses the enable even on a wrap cycle.
               if (w_stop) begin
                  r_state  <= ST_HALT;
                  r_cpu_en <= 1'b0;
               end else if (r_div == c_DIV_LAST) begin
                  r_div    <= '0;
                  r_cpu_en <= 1'b1;
               end else begin
                  r_div    <= r_div + 1'b1;
                  r_cpu_en <= 1'b0;
               end
            end
            ST_STEP: begin
               r_state  <= ST_HALT;
               r_cpu_en <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_reset   = r_cpu_reset;
   assign cpu_en      = r_cpu_en;
   assign state       = r_state;
   assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mips_run_ctrl : self-checking bench for the run/step/halt          |
// |                    sequencer. Rev 1.0                                 |
// +----------------------------------------------------------------------+
module tb_mips_run_ctrl;

   localparam int TICK_DIV   = 4;
   localparam int DEB_CYCLES = 3;
   localparam int RST_HOLD   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        run_sw;
   logic        step_btn;
   logic        halt_req;
   logic        cpu_reset;
   logic        cpu_en;
   logic [1:0]  state;
   logic [31:0] cycle_count;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_pulses = 0;
   logic prev_en  = 1'b0;

   always #5 clk = ~clk;

   mips_run_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .DEB_CYCLES (DEB_CYCLES),
      .RST_HOLD   (RST_HOLD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run_sw      (run_sw),
      .step_btn    (step_btn),
      .halt_req    (halt_req),
      .cpu_reset   (cpu_reset),
      .cpu_en      (cpu_en),
      .state       (state),
      .cycle_count (cycle_count)
   );

   // Reference model: raw-sample history windows and cycle counters.
   bit          q_run[$];
   bit          q_step[$];
   bit          m_run_db, m_step_db, m_rise;
   int          m_state, m_rst_cycles, m_run_cycles;
   bit          m_en, m_creset;
   logic [31:0] m_count;

   typedef struct {
      bit run;
      bit step;
      bit halt;
      int cycles;
      int exp_state;
      int exp_pulses;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Debounced value moves only if the last DEB_CYCLES synced samples all disagree.
   function automatic bit deb_next(input bit q[$], input bit db);
      int n = q.size();
      for (int i = 0; i < DEB_CYCLES; i++) begin
         if (q[n-2-i] == db) return db;
      end
      return !db;
   endfunction

   task automatic model_reset();
      q_run.delete();
      q_step.delete();
      repeat (DEB_CYCLES + 2) begin
         q_run.push_back(1'b0);
         q_step.push_back(1'b0);
      end
      m_run_db = 0; m_step_db = 0; m_rise = 0;
      m_state = 0; m_rst_cycles = 0; m_run_cycles = 0;
      m_en = 0; m_creset = 1; m_count = '0;
   endtask

   task automatic model_edge();
      bit new_run;
      bit new_step;
      if (reset) begin
         model_reset();
      end else begin
         if (m_en) m_count = m_count + 32'd1;
         case (m_state)
            0: begin
               m_rst_cycles++;
               if (m_rst_cycles == RST_HOLD) begin
                  m_state = 1;
                  m_creset = 0;
               end
            end
            1: begin
               if (m_run_db && !halt_req) begin
                  m_state = 2;
                  m_run_cycles = 0;
               end else if (m_rise) begin
                  m_state = 3;
                  m_en = 1;
               end
            end
            2: begin
               m_run_cycles++;
               if (!m_run_db || halt_req) begin
                  m_state = 1;
                  m_en = 0;
               end else begin
                  m_en = (m_run_cycles % TICK_DIV) == 0;
               end
            end
            default: begin
               m_state = 1;
               m_en = 0;
            end
         endcase
         new_run  = deb_next(q_run, m_run_db);
         new_step = deb_next(q_step, m_step_db);
         m_rise    = new_step && !m_step_db;
         m_run_db  = new_run;
         m_step_db = new_step;
         q_run.push_back(run_sw);
         q_step.push_back(step_btn);
         void'(q_run.pop_front());
         void'(q_step.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("model_state", 32'(state), 32'(m_state));
      chk("model_cpu_en", 32'(cpu_en), 32'(m_en));
      chk("model_cpu_reset", 32'(cpu_reset), 32'(m_creset));
      chk("model_cycle_count", cycle_count, m_count);
      chk("en_back_to_back", 32'(prev_en & cpu_en), 32'd0);
      if (cpu_en) n_pulses++;
      prev_en = cpu_en;
   endtask

   task automatic wait_state(input string name, input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (int'(state) == target) break;
         tick();
      end
      chk(name, 32'(state), 32'(target));
   endtask

   initial begin
      int p0;
      logic [31:0] c0;

      vecs[0] = '{1, 0, 0, 12, 2, 1};
      vecs[1] = '{1, 0, 0,  8, 2, 2};
      vecs[2] = '{1, 0, 1,  2, 1, 0};
      vecs[3] = '{0, 0, 1,  8, 1, 0};
      vecs[4] = '{0, 1, 0, 10, 1, 1};
      vecs[5] = '{0, 1, 0, 10, 1, 0};
      vecs[6] = '{0, 0, 0, 10, 1, 0};
      vecs[7] = '{0, 1, 1, 10, 1, 1};
      vecs[8] = '{0, 0, 0, 10, 1, 0};

      model_reset();
      reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;

      // Reset and hold-off
      repeat (3) tick();
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("reset_cpu_en", 32'(cpu_en), 32'd0);
      chk("reset_count", cycle_count, 32'd0);
      reset = 1'b0;
      tick();
      chk("hold_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("hold_state", 32'(state), 32'd0);
      tick();
      chk("release_cpu_reset", 32'(cpu_reset), 32'd0);
      chk("release_state", 32'(state), 32'd1);
      chk("release_count", cycle_count, 32'd0);
      repeat (3) tick();

      for (int i = 0; i < 9; i++) begin
         p0 = n_pulses;
         run_sw = vecs[i].run; step_btn = vecs[i].step; halt_req = vecs[i].halt;
         repeat (vecs[i].cycles) tick();
         chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
         chk($sformatf("vec%0d_pulses", i), 32'(n_pulses - p0), 32'(vecs[i].exp_pulses));
      end

      // Step latency: pulse appears on the 6th clock after the raw edge
      c0 = cycle_count;
      step_btn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("step_early_en", 32'(cpu_en), 32'd0);
      end
      tick();
      chk("step_en", 32'(cpu_en), 32'd1);
      chk("step_state", 32'(state), 32'd3);
      tick();
      chk("step_after_state", 32'(state), 32'd1);
      chk("step_after_en", 32'(cpu_en), 32'd0);
      repeat (13) tick();
      chk("step_held_count", cycle_count - c0, 32'd1);
      step_btn = 1'b0;
      repeat (8) tick();

      // Breakpoint landing on a divider wrap
      run_sw = 1'b1;
      wait_state("bp_enter_run", 2, 20);
      repeat (3) tick();
      halt_req = 1'b1;
      tick();
      chk("bp_wrap_en", 32'(cpu_en), 32'd0);
      chk("bp_state", 32'(state), 32'd1);
      p0 = n_pulses;
      step_btn = 1'b1;
      repeat (10) tick();
      chk("bp_step_pulses", 32'(n_pulses - p0), 32'd1);
      run_sw = 1'b0; step_btn = 1'b0;
      repeat (8) tick();
      halt_req = 1'b0;
      repeat (2) tick();

      // Bouncing button
      p0 = n_pulses;
      for (int i = 0; i < 10; i++) begin
         step_btn = ~step_btn;
         tick();
      end
      chk("bounce_no_pulse", 32'(n_pulses - p0), 32'd0);
      step_btn = 1'b1;
      repeat (10) tick();
      chk("bounce_one_pulse", 32'(n_pulses - p0), 32'd1);
      step_btn = 1'b0;
      repeat (8) tick();

      // Reset in the middle of RUN
      run_sw = 1'b1;
      wait_state("mid_enter_run", 2, 20);
      repeat (6) tick();
      reset = 1'b1;
      tick();
      chk("mid_reset_en", 32'(cpu_en), 32'd0);
      chk("mid_reset_count", cycle_count, 32'd0);
      chk("mid_reset_state", 32'(state), 32'd0);
      reset = 1'b0; run_sw = 1'b0;
      wait_state("mid_back_halt", 1, 10);

      // Counter wrap
      force dut.r_cycle_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_cycle_count;
      m_count = 32'hFFFF_FFFF;
      chk("wrap_loaded", cycle_count, 32'hFFFF_FFFF);
      step_btn = 1'b1;
      repeat (10) tick();
      chk("wrap_count", cycle_count, 32'd0);
      step_btn = 1'b0;
      repeat (8) tick();

      // Randomized segments against the model
      for (int s = 0; s < 150; s++) begin
         int len;
         len = int'($urandom_range(1, 14));
         if ($urandom_range(0, 2) == 0) run_sw = ~run_sw;
         step_btn = 1'($urandom_range(0, 1));
         halt_req = ($urandom_range(0, 4) == 0);
         reset    = ($urandom_range(0, 40) == 0);
         for (int k = 0; k < len; k++) begin
            tick();
            reset = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
